multi_drop_master: RTL and testbench
====================================

MULTI_DROP_MASTER -- requirements
Module: multi_drop_master

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: in_data  input  8  write payload from requester.
REQ-004 SHALL have port: in_dest  input  2  destination select: 00=A, 01=B, 10=C, 11=invalid.
REQ-005 SHALL have port: in_valid  input  1  requester offers in_data/in_dest.
REQ-006 SHALL have port: in_ready  output  1  block can accept; transfer occurs on the edge where in_valid and in_ready are both 1.
REQ-007 SHALL have port: bus  output  8  data driven to the multi-drop bus.
REQ-008 SHALL have ports: ena, enb, enc  output  1 each  load strobes for drops A/B/C.
REQ-009 SHALL have port: busy  output  1  high whenever state is not IDLE or the FIFO is non-empty.
REQ-010 SHALL have port: count  output  3  current FIFO occupancy, 0..4.
REQ-011 SHALL have port: err_dest  output  1  one-cycle pulse on an accepted request with in_dest=11.
REQ-012 SHALL have parameter: DEPTH, default 4, FIFO entries; only value 4 is required.

Function
REQ-013 SHALL buffer accepted requests in a DEPTH-entry FIFO, in order, using a 2-bit read pointer and a 2-bit write pointer that wrap 3->0.
REQ-014 SHALL drive in_ready = (count != 4), combinationally from registered count only; a same-cycle pop never enables a push when full.
REQ-015 SHALL store an accepted request with in_dest=11 nowhere, leave count unchanged, and set err_dest=1 for exactly the following cycle.
REQ-016 SHALL leave count unchanged on the same edge as a valid push and a pop; push-only adds 1; pop-only subtracts 1.
REQ-017 SHALL implement FSM states IDLE, SETUP, STROBE.
REQ-018 IDLE: if count!=0, go to SETUP and load bus with head data; else stay.
REQ-019 SETUP: lasts exactly one cycle; bus holds head data; ena/enb/enc all 0; next state STROBE.
REQ-020 STROBE: lasts exactly one cycle; exactly one strobe =1, selected by head dest; bus unchanged; the FIFO pops on the edge leaving STROBE.
REQ-021 On leaving STROBE, SHALL go to SETUP and load bus with the next entry if post-pop count!=0, else to IDLE.
REQ-022 All outputs except in_ready SHALL be registered; strobes SHALL never be asserted in IDLE or SETUP.
REQ-023 bus SHALL hold its last driven value in IDLE.
REQ-024 Latency: a push into an empty FIFO in IDLE at edge N gives SETUP in cycle N+1..N+2 and STROBE in N+2..N+3; the drop captures at edge N+3.
REQ-025 Throughput: back-to-back entries SHALL transfer one every 2 cycles, with no IDLE cycle between them.
REQ-026 At most one of ena/enb/enc SHALL be high in any cycle.

Reset
REQ-027 On the edge with rst=1: FIFO pointers=0, count=0, state=IDLE, bus=8'h00, ena=enb=enc=0, err_dest=0, busy=0; in_ready=1 after that edge.
REQ-028 rst SHALL override push, pop and state advance on the same edge; a request offered during reset is discarded.
REQ-029 Reset mid-transfer (SETUP or STROBE) SHALL clear the strobe at that edge and drop all pending entries; there is no partial transfer afterwards.

Verification
REQ-030 Single write: push (8'h36, 00) into idle block -> 1 cycle later bus=8'h36 with strobes 0; next cycle ena=1 for one cycle, bus=8'h36; then IDLE, count=0.
REQ-031 Burst: push 8'h36/00, 8'h4F/01, 8'hF6/10 on consecutive cycles -> strobes ena, enb, enc in order, 2 cycles apart, with bus 36, 4F, F6 during the respective strobe.
REQ-032 Full: hold the state machine busy and push 5 entries -> in_ready=0 once count=4; 5th not accepted until the first pop; no entry lost or duplicated.
REQ-033 Invalid dest: push (8'hAA, 11) -> err_dest=1 for one cycle, count stays 0, no strobe ever asserts.
REQ-034 Reset mid-STROBE with 2 entries queued -> next cycle strobes=0, bus=8'h00, count=0, in_ready=1, state IDLE.
REQ-035 Wrap: push and drain 6 entries in sequence -> pointers wrap; data order preserved; count returns to 0.

Source files
------------

// File: rtl/multi_drop_master.sv
// multi_drop_master
// Buffers write requests in a small FIFO and delivers each one to one of
// three drops (A/B/C) sharing a multi-drop data bus. Each transfer is a
// two-cycle sequence: SETUP (bus driven, no strobe) then STROBE (bus held,
// exactly one load strobe high). The FIFO pops on the edge leaving STROBE.
//
// Ports
//   clk       clock, all state updates on rising edge
//   rst       synchronous active-high reset
//   in_data   write payload
//   in_dest   destination: 00=A, 01=B, 10=C, 11=invalid
//   in_valid  request offered
//   in_ready  request can be accepted (combinational from registered count)
//   bus       data on the multi-drop bus (registered, held while idle)
//   ena/enb/enc load strobes for drops A/B/C (registered)
//   busy      FSM not idle or FIFO non-empty (registered)
//   count     FIFO occupancy 0..DEPTH
//   err_dest  one-cycle pulse after an accepted request with in_dest=11
module multi_drop_master #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic [1:0] in_dest,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] bus,
    output logic       ena,
    output logic       enb,
    output logic       enc,
    output logic       busy,
    output logic [2:0] count,
    output logic       err_dest
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

    state_t     state, state_nx;
    logic [7:0] mem_data [DEPTH];
    logic [1:0] mem_dest [DEPTH];
    logic [1:0] rptr, wptr, rnext;
    logic       accept, push, pop;
    logic [2:0] count_nx;
    logic [7:0] bus_nx;
    logic       ena_nx, enb_nx, enc_nx, busy_nx;

    // in_ready looks only at the registered count, so a pop on the same
    // edge never lets a push into a full FIFO.
    assign in_ready = (count != 3'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_dest != 2'b11);
    assign pop      = (state == STROBE);
    assign rnext    = rptr + 2'd1;

    always_comb begin
        case ({push, pop})
            2'b10:   count_nx = count + 3'd1;
            2'b01:   count_nx = count - 3'd1;
            default: count_nx = count;
        endcase
    end

    always_comb begin
        state_nx = state;
        bus_nx   = bus;
        ena_nx   = 1'b0;
        enb_nx   = 1'b0;
        enc_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (count != 3'd0) begin
                    state_nx = SETUP;
                    bus_nx   = mem_data[rptr];
                end
            end
            SETUP: begin
                state_nx = STROBE;
                case (mem_dest[rptr])
                    2'b00:   ena_nx = 1'b1;
                    2'b01:   enb_nx = 1'b1;
                    2'b10:   enc_nx = 1'b1;
                    default: ;
                endcase
            end
            STROBE: begin
                if (count_nx != 3'd0) begin
                    state_nx = SETUP;
                    // With only the head queued, the next entry is the one
                    // being pushed on this very edge, so forward it.
                    bus_nx   = (count >= 3'd2) ? mem_data[rnext] : in_data;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE) || (count_nx != 3'd0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr] <= in_data;
            mem_dest[wptr] <= in_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rptr     <= 2'd0;
            wptr     <= 2'd0;
            count    <= 3'd0;
            bus      <= 8'h00;
            ena      <= 1'b0;
            enb      <= 1'b0;
            enc      <= 1'b0;
            busy     <= 1'b0;
            err_dest <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            bus      <= bus_nx;
            ena      <= ena_nx;
            enb      <= enb_nx;
            enc      <= enc_nx;
            busy     <= busy_nx;
            err_dest <= accept && (in_dest == 2'b11);
            if (push) wptr <= wptr + 2'd1;
            if (pop)  rptr <= rnext;
        end
    end

endmodule

// File: tb/tb_multi_drop_master.sv
// Bench for multi_drop_master: a queue-based model of the request stream
// checked against the DUT on every cycle, plus directed scenarios with
// literal expectations.
module tb_multi_drop_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic [1:0] in_dest = 2'b00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] bus;
    logic       ena, enb, enc, busy, err_dest;
    logic [2:0] count;

    multi_drop_master #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest),
        .in_valid(in_valid), .in_ready(in_ready), .bus(bus),
        .ena(ena), .enb(enb), .enc(enc), .busy(busy), .count(count),
        .err_dest(err_dest)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [7:0] d;
        logic [1:0] k;
    } ent_t;

    ent_t       q[$];
    int         ph = 0;     // 0: no transfer, 1: data setup, 2: strobe
    logic [7:0] m_bus = 8'h00;
    logic       m_a = 0, m_b = 0, m_c = 0, m_err = 0, m_busy = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            ph = 0; m_bus = 8'h00;
            m_a = 0; m_b = 0; m_c = 0; m_err = 0; m_busy = 0;
        end else begin
            int   n0;
            bit   acc;
            ent_t e;
            n0  = q.size();
            acc = in_valid && (n0 != 4);
            m_err = acc && (in_dest == 2'b11);
            m_a = 0; m_b = 0; m_c = 0;
            if (ph == 2) void'(q.pop_front());
            if (acc && in_dest != 2'b11) begin
                e.d = in_data; e.k = in_dest;
                q.push_back(e);
            end
            case (ph)
                0: if (n0 != 0) begin ph = 1; m_bus = q[0].d; end
                1: begin
                    ph  = 2;
                    m_a = (q[0].k == 2'd0);
                    m_b = (q[0].k == 2'd1);
                    m_c = (q[0].k == 2'd2);
                end
                default: if (q.size() != 0) begin ph = 1; m_bus = q[0].d; end
                         else ph = 0;
            endcase
            m_busy = (ph != 0) || (q.size() != 0);
        end
    end

    // ---------------- per-cycle compare + strobe log ----------------
    logic [7:0] log_d[$];
    int         log_k[$];
    int         log_c[$];

    always @(negedge clk) begin
        cyc++;
        if (chk_on) begin
            chk("in_ready", 8'(in_ready), 8'(q.size() != 4));
            chk("bus",      bus,          m_bus);
            chk("ena",      8'(ena),      8'(m_a));
            chk("enb",      8'(enb),      8'(m_b));
            chk("enc",      8'(enc),      8'(m_c));
            chk("busy",     8'(busy),     8'(m_busy));
            chk("count",    8'(count),    8'(q.size()));
            chk("err_dest", 8'(err_dest), 8'(m_err));
            chk("onehot",   8'(32'(ena) + 32'(enb) + 32'(enc) <= 1), 8'd1);
        end
        if (ena || enb || enc) begin
            log_d.push_back(bus);
            log_k.push_back(ena ? 0 : (enb ? 1 : 2));
            log_c.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    bit saw_full;

    task automatic push(input logic [7:0] d, input logic [1:0] k);
        bit ok;
        ok = 1'b0;
        in_data = d; in_dest = k; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            saw_full = 1'b1;
        end
        if (!ok) begin
            bad++;
            $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic clear_log();
        log_d.delete(); log_k.delete(); log_c.delete();
    endtask

    logic [7:0] bd[3] = '{8'h36, 8'h4F, 8'hF6};
    logic [7:0] exp_d[$];
    int         exp_k[$];

    task automatic check_log(input string nm);
        chk({nm, "_n"}, 8'(log_d.size()), 8'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < log_d.size(); i++) begin
            chk({nm, "_data"}, log_d[i], exp_d[i]);
            chk({nm, "_drop"}, 8'(log_k[i]), 8'(exp_k[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        @(posedge clk); #2;
        do_reset();
        chk_on = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_ready", 8'(in_ready), 8'd1);
        chk("rst_bus", bus, 8'h00);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_err", 8'(err_dest), 8'd0);

        // single write
        @(posedge clk); #2;
        push(8'h36, 2'b00);
        @(negedge clk);
        chk("single_cnt1", 8'(count), 8'd1);
        @(negedge clk);
        chk("single_setup_bus", bus, 8'h36);
        chk("single_setup_ena", 8'({ena, enb, enc}), 8'd0);
        @(negedge clk);
        chk("single_strobe_ena", 8'(ena), 8'd1);
        chk("single_strobe_bus", bus, 8'h36);
        @(negedge clk);
        chk("single_end_ena", 8'(ena), 8'd0);
        chk("single_end_cnt", 8'(count), 8'd0);
        chk("single_end_busy", 8'(busy), 8'd0);
        chk("single_hold_bus", bus, 8'h36);
        @(posedge clk); #2;

        // burst of three, 2 cycles apart
        clear_log();
        push(8'h36, 2'b00);
        push(8'h4F, 2'b01);
        push(8'hF6, 2'b10);
        repeat (10) @(posedge clk);
        #2;
        exp_d.delete(); exp_k.delete();
        for (int i = 0; i < 3; i++) begin exp_d.push_back(bd[i]); exp_k.push_back(i); end
        check_log("burst");
        if (log_c.size() == 3) begin
            chk("burst_gap1", 8'(log_c[1] - log_c[0]), 8'd2);
            chk("burst_gap2", 8'(log_c[2] - log_c[1]), 8'd2);
        end

        // invalid destination
        clear_log();
        push(8'hAA, 2'b11);
        @(negedge clk);
        chk("inv_err", 8'(err_dest), 8'd1);
        chk("inv_cnt", 8'(count), 8'd0);
        @(negedge clk);
        chk("inv_err_clear", 8'(err_dest), 8'd0);
        repeat (6) @(negedge clk);
        chk("inv_no_strobe", 8'(log_d.size()), 8'd0);
        @(posedge clk); #2;

        // full FIFO: push faster than drain
        clear_log();
        exp_d.delete(); exp_k.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(8'h10 + 8'(i), 2'(i % 3));
            exp_d.push_back(8'h10 + 8'(i));
            exp_k.push_back(i % 3);
        end
        chk("full_stall_seen", 8'(saw_full), 8'd1);
        repeat (20) @(posedge clk);
        #2;
        check_log("full");

        // reset during STROBE with entries queued
        push(8'h51, 2'b01);
        push(8'h52, 2'b10);
        push(8'h53, 2'b00);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ena || enb || enc) begin got = 1'b1; break; end
        end
        chk("mid_strobe_reached", 8'(got), 8'd1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        clear_log();
        @(negedge clk);
        chk("midrst_strobes", 8'({ena, enb, enc}), 8'd0);
        chk("midrst_bus", bus, 8'h00);
        chk("midrst_cnt", 8'(count), 8'd0);
        chk("midrst_ready", 8'(in_ready), 8'd1);
        chk("midrst_busy", 8'(busy), 8'd0);
        repeat (8) @(negedge clk);
        chk("midrst_no_partial", 8'(log_d.size()), 8'd0);
        @(posedge clk); #2;

        // pointer wrap: six sequential transfers
        clear_log();
        exp_d.delete(); exp_k.delete();
        for (int i = 0; i < 6; i++) begin
            push(8'hC0 + 8'(i * 5), 2'((i + 1) % 3));
            exp_d.push_back(8'hC0 + 8'(i * 5));
            exp_k.push_back((i + 1) % 3);
            repeat (5) @(posedge clk);
            #2;
        end
        check_log("wrap");
        @(negedge clk);
        chk("wrap_cnt", 8'(count), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
